// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: request/response bundle between requesters and the shared multiplier
//   req_valid/req_ready : per-requester handshake, NUM_REQ bits
//   req_a/req_b         : packed operands, requester k at [k*OPERAND_SIZE +: OPERAND_SIZE]
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id              : index of the requester owning the response
//   rsp_product         : unsigned product, 2*OPERAND_SIZE bits
//   busy                : arbiter has a transaction in flight
interface mult_share_arbiter_if #(
    parameter int OPERAND_SIZE = 16,
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*OPERAND_SIZE-1:0] req_a;
    logic [NUM_REQ*OPERAND_SIZE-1:0] req_b;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [ID_W-1:0]                 rsp_id;
    logic [2*OPERAND_SIZE-1:0]       rsp_product;
    logic                            busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one combinational array multiplier among NUM_REQ requesters
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_share_arbiter_if.slave (request ports, tagged response port, busy)
// mult_32: exact unsigned operandSize x operandSize array multiplier (combinational)
//   a, b    : operands
//   product : a*b, 2*operandSize bits
module mult_32 #(
    parameter int operandSize = 16
) (
    input  logic [operandSize-1:0]   a,
    input  logic [operandSize-1:0]   b,
    output logic [2*operandSize-1:0] product
);
    // Sum of shifted partial-product rows, one row per bit of b.
    always_comb begin
        product = '0;
        for (int i = 0; i < operandSize; i++)
            if (b[i]) product = product + ({{operandSize{1'b0}}, a} << i);
    end
endmodule

module mult_share_arbiter #(
    parameter int OPERAND_SIZE = 16,
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    mult_share_arbiter_if.slave bus
);
    localparam int W  = OPERAND_SIZE;
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, MULT, RESP} state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   idx;
    logic            found;
    logic [W-1:0]    a_arr [NUM_REQ];
    logic [W-1:0]    b_arr [NUM_REQ];
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IW-1:0]   id_q;
    logic [2*W-1:0]  prod;
    logic [ID_W-1:0] rsp_id_q;
    logic [2*W-1:0]  rsp_prod_q;

    genvar k;
    for (k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign a_arr[k] = bus.req_a[k*W +: W];
        assign b_arr[k] = bus.req_b[k*W +: W];
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    mult_32 #(.operandSize(W)) u_mult (
        .a       (a_q),
        .b       (b_q),
        .product (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = found ? MULT : IDLE;
            MULT:    next_state = RESP;
            RESP:    next_state = bus.rsp_ready ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
        end else if (state == IDLE && found) begin
            a_q  <= a_arr[gnt];
            b_q  <= b_arr[gnt];
            id_q <= gnt;
            ptr  <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end else if (state == MULT) begin
            rsp_prod_q <= prod;
            rsp_id_q   <= ID_W'(id_q);
        end
    end

    // Gated by rst_n so no grant is advertised while reset is held.
    assign bus.req_ready   = (rst_n && state == IDLE && found) ? (NUM_REQ'(1) << gnt) : '0;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.busy        = (state != IDLE);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_prod_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and random checks of mult_share_arbiter against a transaction-level model
module tb_mult_share_arbiter;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.OPERAND_SIZE(W), .NUM_REQ(N), .ID_W(IDW)) bus ();

    mult_share_arbiter #(.OPERAND_SIZE(W), .NUM_REQ(N), .ID_W(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: phase 0 = free, 1 = computing, 2 = response pending
    int          phase;
    int          m_ptr;
    int          m_gid;
    int          m_rid;
    logic [31:0] m_prod;
    logic [31:0] m_rprod;
    int          cyc = 0;
    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];
    int          dut_ids[$];
    logic [31:0] dut_prods[$];
    int          hs_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic rr);
        int g;
        logic [N-1:0] er;
        for (int k = 0; k < N; k++) begin
            bus.req_a[k*W +: W] = a_v[k];
            bus.req_b[k*W +: W] = b_v[k];
        end
        bus.req_valid = v;
        bus.rsp_ready = rr;
        if (!rst_n) begin
            phase = 0; m_ptr = 0; m_rid = 0; m_rprod = 0;
        end
        #1;
        g = -1;
        if (rst_n && phase == 0)
            for (int i = 0; i < N; i++)
                if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("busy", 64'(bus.busy), 64'(phase != 0));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(phase == 2));
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_rid));
        chk("rsp_product", 64'(bus.rsp_product), 64'(m_rprod));
        if (rst_n && bus.rsp_valid && rr) begin
            dut_ids.push_back(int'(bus.rsp_id));
            dut_prods.push_back(bus.rsp_product);
            hs_cyc.push_back(cyc);
        end
        if (rst_n) begin
            if (g >= 0) begin
                m_prod = 32'(a_v[g]) * 32'(b_v[g]);
                m_gid  = g;
                m_ptr  = (g + 1) % N;
                phase  = 1;
            end else if (phase == 1) begin
                phase   = 2;
                m_rid   = m_gid;
                m_rprod = m_prod;
            end else if (phase == 2 && rr) begin
                phase = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(N'($urandom), 1'($urandom));
        step(N'($urandom), 1'($urandom));
        rst_n = 1'b1;
        dut_ids.delete();
        dut_prods.delete();
        hs_cyc.delete();
    endtask

    int exp_ids[5];
    logic [31:0] exp_prods[5];

    initial begin
        for (int k = 0; k < N; k++) begin
            a_v[k] = W'($urandom);
            b_v[k] = W'($urandom);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        phase = 0; m_ptr = 0; m_rid = 0; m_rprod = 0; m_gid = 0; m_prod = 0;
        @(negedge clk);

        // Reset with random inputs, then idle
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(N'($urandom), 1'($urandom));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step('0, 1'b1);

        // Single request with all-ones operands
        do_reset();
        a_v[1] = 16'hFFFF; b_v[1] = 16'hFFFF;
        step(4'b0010, 1'b1);
        for (int i = 0; i < 4; i++) step('0, 1'b1);
        chk("single_count", 64'(dut_ids.size()), 64'd1);
        if (dut_ids.size() >= 1) begin
            chk("single_id", 64'(dut_ids[0]), 64'd1);
            chk("single_prod", 64'(dut_prods[0]), 64'hFFFE0001);
        end

        // Round robin, all requesters valid from reset
        do_reset();
        for (int k = 0; k < N; k++) begin a_v[k] = W'(k + 3); b_v[k] = 16'd5; end
        for (int i = 0; i < 16; i++) step(4'b1111, 1'b1);
        exp_ids   = '{0, 1, 2, 3, 0};
        exp_prods = '{32'd15, 32'd20, 32'd25, 32'd30, 32'd15};
        chk("rr_count", 64'(dut_ids.size() >= 5), 64'd1);
        if (dut_ids.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("rr_id", 64'(dut_ids[i]), 64'(exp_ids[i]));
                chk("rr_prod", 64'(dut_prods[i]), 64'(exp_prods[i]));
                if (i > 0) chk("rr_interval", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
            end

        // Backpressure
        do_reset();
        for (int k = 0; k < N; k++) begin a_v[k] = W'($urandom); b_v[k] = W'($urandom); end
        for (int i = 0; i < 7; i++) step(4'b1111, 1'b0);
        chk("bp_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b1);
        chk("bp_count", 64'(dut_ids.size()), 64'd2);

        // Fairness between requesters 0 and 2, requester 0 multiplies by zero
        do_reset();
        a_v[0] = '0; b_v[0] = W'($urandom);
        a_v[2] = W'($urandom); b_v[2] = W'($urandom);
        for (int i = 0; i < 13; i++) step(4'b0101, 1'b1);
        chk("fair_count", 64'(dut_ids.size() >= 4), 64'd1);
        if (dut_ids.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("fair_id", 64'(dut_ids[i]), 64'((i % 2) * 2));
                if (i % 2 == 0) chk("fair_zero", 64'(dut_prods[i]), 64'd0);
            end

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                a_v[k] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                b_v[k] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            end
            step(N'($urandom), $urandom_range(0, 9) < 7);
        end

        // Reset during MULT discards the transaction and rewinds the pointer
        do_reset();
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        a_v[1] = 16'h1234; b_v[1] = 16'h00FF;
        step(4'b0010, 1'b1);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        step('0, 1'b1);
        step(4'b1001, 1'b1);
        rst_n = 1'b1;
        chk("mid_no_rsp", 64'(dut_ids.size()), 64'd0);
        step(4'b1001, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b1001, 1'b1);
        chk("mid_first", 64'(dut_ids.size() >= 2), 64'd1);
        if (dut_ids.size() >= 2) begin
            chk("mid_id0", 64'(dut_ids[0]), 64'd0);
            chk("mid_id1", 64'(dut_ids[1]), 64'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one exact unsigned array multiplier (mult_32 instance, combinational) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every request port and on a single tagged response port.
- Operands and product are registered around the combinational array, so its long carry chain gets a full clock cycle.
- Sits between the requesting datapath units and the multiplier; one transaction in flight at a time.

Parameters:
- OPERAND_SIZE, 16, operand width W; passed to the mult_32 instance as operandSize.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, response tag width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*W  operand A, requester k at bits [k*W +: W].
- req_b  in  NUM_REQ*W  operand B, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of requester owning the response.
- rsp_product  out  2W  unsigned product a*b.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr pointer=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, req_ready=0.
- Any in-flight transaction is discarded on reset; no response for it is ever issued.
- FSM states: IDLE, MULT, RESP.
- IDLE:
  - Grant g = first k with req_valid[k]=1, searching ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - req_ready[g]=1 combinationally; all other bits 0; all bits 0 if no valid.
  - On req_valid[g]&req_ready[g]: latch req_a/req_b slice g and id g; ptr <= (g+1) mod NUM_REQ; go to MULT.
  - Arbitration is re-evaluated every IDLE cycle; a requester may drop valid before acceptance without penalty.
- MULT (exactly 1 cycle):
  - Registered operands drive the multiplier.
  - At the clock edge: rsp_product <= product, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_product held stable until rsp_valid&rsp_ready.
  - Then rsp_valid <= 0, go to IDLE.
  - rsp_product and rsp_id keep their last values after the handshake.
- req_ready is 0 in MULT and RESP, so no request is accepted while busy.
- Latency: acceptance edge at cycle 0; rsp_valid high from cycle 2. With rsp_ready tied 1, minimum issue interval is 3 cycles (the next accept is at the earliest in the cycle after the response handshake).
- Arithmetic: unsigned W x W -> 2W product, exact, no truncation or overflow.
- Boundary cases:
  - Operand 0 gives product 0.
  - All-ones operands give product (2^W-1)^2.
  - All requesters valid: served in pointer order, each once before any repeats.
  - Single requester with continuous valid is served back-to-back at the 3-cycle interval.
  - Pointer wraps from NUM_REQ-1 to 0.
  - rsp_ready already high when rsp_valid rises: handshake completes in that same cycle.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, req_ready=0000. Release; req_valid=0000 -> state stays IDLE, busy=0.
- Single request (W=16, N=4, rsp_ready=1): req_valid[1]=1, a=0xFFFF, b=0xFFFF -> req_ready=0010 in cycle 0; rsp_valid=1 in cycle 2 with rsp_product=0xFFFE0001, rsp_id=1; busy=0 again in cycle 3.
- Round-robin: all four valid continuously from reset, requester k supplies a=k+3, b=5 -> responses in id order 0,1,2,3,0 with products 15,20,25,30,15, spaced 3 cycles apart.
- Backpressure: after a rsp_valid, hold rsp_ready=0 for 5 cycles -> rsp_product/rsp_id stable, req_ready=0000, busy=1. Raise rsp_ready -> rsp_valid drops next cycle and the next grant occurs.
- Fairness and zero operand: req_valid[0] and req_valid[2] held high, requester 0 has a=0 -> ids alternate 0,2,0,2; id-0 products all 0x00000000.
- Reset mid-operation: assert rst_n=0 during MULT -> rsp_valid never rises for that transaction, pointer returns to 0. After release, requesters 3 and 0 both valid -> requester 0 granted first.
